// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared types and constants for the VGA timing generator.
//   vga_phase_t   : per-axis phase (ACTIVE, FRONT, SYNC, BACK)
//   DEF_*         : default 640x480@60 Hz timing (25.175 MHz pixel clock)
//   COORD_W       : width of the column/row coordinate outputs
//   FRAME_CNT_W   : width of the frame counter output
//   vga_total()   : total length of one axis from its four segments
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } vga_phase_t;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_PULSE  = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_PIXELS = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_PULSE  = 2;
  localparam int DEF_V_BP     = 33;

  localparam int COORD_W     = 32;
  localparam int FRAME_CNT_W = 16;

  function automatic int vga_total(input int active_len, input int fp,
                                   input int pulse, input int bp);
    return active_len + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One display axis: a position counter 0..TOTAL-1 plus its phase FSM
// (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE). Both move only when
// `advance` is high.
// Ports:
//   pixel_clk  in   pixel clock
//   reset_n    in   asynchronous active-low reset
//   advance    in   step the counter/FSM this cycle
//   wrap       out  counter is at TOTAL-1 and advancing (combinational)
//   phase      out  current phase (from flops)
//   count      out  current position (from flops)
//   sync       out  sync level for the current phase (POL in SYNC)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE_LEN = DEF_H_PIXELS,
  parameter int   FP         = DEF_H_FP,
  parameter int   PULSE      = DEF_H_PULSE,
  parameter int   BP         = DEF_H_BP,
  parameter logic POL        = 1'b0,
  parameter int   CNT_W      = $clog2(vga_total(ACTIVE_LEN, FP, PULSE, BP))
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic             advance,
  output logic             wrap,
  output vga_phase_t       phase,
  output logic [CNT_W-1:0] count,
  output logic             sync
);

  localparam int TOTAL = vga_total(ACTIVE_LEN, FP, PULSE, BP);

  // Last position of each phase; the FSM leaves the phase when the counter
  // steps off this value.
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] FRONT_LAST  = CNT_W'(ACTIVE_LEN + FP - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(ACTIVE_LEN + FP + PULSE - 1);
  localparam logic [CNT_W-1:0] TOTAL_LAST  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  vga_phase_t       phase_q, phase_d;
  logic             at_last_s;

  assign at_last_s = (count_q == TOTAL_LAST);

  // State register: position counter and phase.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= CNT_W'(0);
      phase_q <= ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic: counter wraps at TOTAL-1, phase follows boundaries.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (advance) begin
      if (at_last_s) begin
        count_d = CNT_W'(0);
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      case (phase_q)
        ACTIVE:  if (count_q == ACTIVE_LAST) phase_d = FRONT;  else phase_d = ACTIVE;
        FRONT:   if (count_q == FRONT_LAST)  phase_d = SYNC;   else phase_d = FRONT;
        SYNC:    if (count_q == SYNC_LAST)   phase_d = BACK;   else phase_d = SYNC;
        BACK:    if (at_last_s)              phase_d = ACTIVE; else phase_d = BACK;
        default: phase_d = ACTIVE;
      endcase
    end else begin
      count_d = count_q;
      phase_d = phase_q;
    end
  end

  // Output decode: wrap pulse and sync level for the current phase.
  always_comb begin
    wrap = advance && at_last_s;
    if (phase_q == SYNC) begin
      sync = POL;
    end else begin
      sync = ~POL;
    end
  end

  assign phase = phase_q;
  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Pixel-clock VGA timing generator. Every output is a flop whose value
// reflects the counter state held before the edge (one cycle latency).
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN enables the frame
// counter; without it frame_cnt is tied to 0.
// Ports:
//   pixel_clk    in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   h_sync       out  horizontal sync (H_POL during sync pulse)
//   v_sync       out  vertical sync (V_POL during sync pulse)
//   disp_ena     out  high in the active region
//   column       out  x coordinate, held outside the active region
//   row          out  y coordinate, held outside the active region
//   line_start   out  one-cycle strobe at h=0 of every line
//   frame_start  out  one-cycle strobe at (h=0, v=0)
//   frame_cnt    out  frame counter
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_PIXELS = DEF_H_PIXELS,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_PULSE  = DEF_H_PULSE,
  parameter int   H_BP     = DEF_H_BP,
  parameter logic H_POL    = 1'b0,
  parameter int   V_PIXELS = DEF_V_PIXELS,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_PULSE  = DEF_V_PULSE,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic V_POL    = 1'b0
) (
  input  logic                   pixel_clk,
  input  logic                   reset_n,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   disp_ena,
  output logic [COORD_W-1:0]     column,
  output logic [COORD_W-1:0]     row,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_CNT_W = $clog2(vga_total(H_PIXELS, H_FP, H_PULSE, H_BP));
  localparam int V_CNT_W = $clog2(vga_total(V_PIXELS, V_FP, V_PULSE, V_BP));

  logic               h_wrap, v_wrap, h_sync_s, v_sync_s;
  vga_phase_t         h_phase, v_phase;
  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;

  vga_axis_counter #(
    .ACTIVE_LEN(H_PIXELS), .FP(H_FP), .PULSE(H_PULSE), .BP(H_BP),
    .POL(H_POL), .CNT_W(H_CNT_W)
  ) u_h_axis (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .advance(1'b1),
    .wrap(h_wrap), .phase(h_phase), .count(h_cnt), .sync(h_sync_s)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_PIXELS), .FP(V_FP), .PULSE(V_PULSE), .BP(V_BP),
    .POL(V_POL), .CNT_W(V_CNT_W)
  ) u_v_axis (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .advance(h_wrap),
    .wrap(v_wrap), .phase(v_phase), .count(v_cnt), .sync(v_sync_s)
  );

  logic               h_sync_q, v_sync_q, disp_ena_q, line_start_q, frame_start_q;
  logic               h_sync_d, v_sync_d, disp_ena_d, line_start_d, frame_start_d;
  logic [COORD_W-1:0] column_q, column_d, row_q, row_d;

  // Output next-state: decode of the current counter/phase state.
  always_comb begin
    h_sync_d      = h_sync_s;
    v_sync_d      = v_sync_s;
    disp_ena_d    = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    line_start_d  = (h_cnt == H_CNT_W'(0));
    frame_start_d = line_start_d && (v_cnt == V_CNT_W'(0));
    if (disp_ena_d) begin
      column_d = COORD_W'(h_cnt);
      row_d    = COORD_W'(v_cnt);
    end else begin
      column_d = column_q;
      row_d    = row_q;
    end
  end

  // Output registers: syncs and strobes come straight from flops.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      disp_ena_q    <= 1'b0;
      column_q      <= COORD_W'(0);
      row_q         <= COORD_W'(0);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      disp_ena_q    <= disp_ena_d;
      column_q      <= column_d;
      row_q         <= row_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign disp_ena    = disp_ena_q;
  assign column      = column_q;
  assign row         = row_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // frame_wrap_q is high exactly on the (0,0) cycle that follows a
  // completed frame, so the first frame after reset keeps the count at 0
  // and the increment lands on the same edge that outputs frame_start.
  logic                   frame_wrap_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Frame counter next-state: wraps naturally at 2^FRAME_CNT_W.
  always_comb begin
    if (frame_wrap_q) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter registers.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_wrap_q <= 1'b0;
      frame_cnt_q  <= FRAME_CNT_W'(0);
    end else begin
      frame_wrap_q <= v_wrap;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_v_wrap_s;
  assign unused_v_wrap_s = v_wrap;
  assign frame_cnt       = FRAME_CNT_W'(0);
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock timing generator for the pong display path. Counts horizontal and vertical position, produces registered sync, blanking and pixel-coordinate outputs, and adds frame/line strobes. Sits directly upstream of the rectangle/paddle renderer, which consumes `column`, `row` and `disp_ena` and re-registers the syncs. Default parameters give 640x480@60 Hz on the 25.175 MHz PLL clock.

## Interface
- `H_PIXELS`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_PULSE`, 96: h_sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `H_POL`, 0: h_sync active level.
- `V_PIXELS`, 480: active lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_PULSE`, 2: v_sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `V_POL`, 0: v_sync active level.
- `pixel_clk` in 1: pixel clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `h_sync` out 1: horizontal sync, registered.
- `v_sync` out 1: vertical sync, registered.
- `disp_ena` out 1: high in the active region.
- `column` out 32: x coordinate, 0..H_PIXELS-1.
- `row` out 32: y coordinate, 0..V_PIXELS-1.
- `line_start` out 1: one-cycle strobe at h=0 of every line, including blank lines.
- `frame_start` out 1: one-cycle strobe at (h=0, v=0).
- `frame_cnt` out 16: frame counter (see Configuration).

## Operation
- H_TOTAL = H_PIXELS+H_FP+H_PULSE+H_BP (800). V_TOTAL is built the same way (525).
- `h_cnt` runs 0..H_TOTAL-1 and increments every cycle.
  - At H_TOTAL-1 it wraps to 0 and `v_cnt` increments.
  - `v_cnt` at V_TOTAL-1 that also wraps wraps to 0.
- Each axis carries a phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Transitions occur on counter boundaries H_PIXELS, +H_FP, +H_PULSE and the wrap (same rule vertically).
  - The vertical FSM advances only on a horizontal wrap.
- Sync outputs:
  - `h_sync` = H_POL while the horizontal phase is SYNC (h in 656..751), otherwise ~H_POL.
  - `v_sync` = V_POL while the vertical phase is SYNC (v in 490..491), otherwise ~V_POL.
- `disp_ena` = both phases ACTIVE.
- Coordinates:
  - `column`/`row` load h/v, zero-extended to 32 bits, only when `disp_ena` is high.
  - Otherwise they hold their last value.
- Reset values:
  - Counters 0; both FSMs ACTIVE.
  - `h_sync`=~H_POL, `v_sync`=~V_POL.
  - `disp_ena`=0, `column`=0, `row`=0, `line_start`=0, `frame_start`=0, `frame_cnt`=0.
- Reset mid-frame: all state clears immediately and asynchronously. No partial line is completed.

## Timing
- Output latency is 1 cycle. Outputs updated on an edge reflect the counter values held before that edge.
- First edge after `reset_n` rises:
  - Outputs show (0,0): `disp_ena`=1, `column`=0, `row`=0, `line_start`=1, `frame_start`=1.
  - Counters move to (1,0).
- Strobes are high for exactly one cycle. `frame_start` implies `line_start` in the same cycle.
- Per line:
  - `disp_ena` is high for H_PIXELS consecutive cycles on active lines and 0 on blank lines.
  - The line period is H_TOTAL cycles.
- The frame period is H_TOTAL*V_TOTAL cycles (420000).
- Sync edges are glitch-free: driven directly from flops, with no combinational output path.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` increments on the cycle `frame_start` is output, except the first frame after reset, which reads 0.
  - It wraps 65535 -> 0.
- Not defined: `frame_cnt` is tied to 0 and no counter flops are synthesised. The port is always present.

## Structure
- `vga_timing_pkg` holds:
  - the phase enum `vga_phase_t` (ACTIVE, FRONT, SYNC, BACK);
  - the default 640x480 timing constants;
  - the coordinate width constant (32).
- Sub-module `vga_axis_counter` holds one axis: a counter plus its phase FSM, with parameters for the active length, porches, pulse width and polarity.
  - Ports: `advance` in, `wrap` out, `phase` out, `count` out.
  - The horizontal instance has `advance`=1.
  - The vertical instance has `advance` = horizontal `wrap`.

## Test plan
- Reset: hold `reset_n`=0 for 10 cycles -> `h_sync`=1, `v_sync`=1, `disp_ena`=0, `column`=0, `row`=0, strobes 0, `frame_cnt`=0.
- Line timing: run 2 lines -> `disp_ena` high 640 cycles per line, `h_sync` low 96 cycles beginning 656 cycles after `line_start`, `line_start` spacing 800.
- Frame timing: run 1 frame -> 307200 `disp_ena` cycles, `v_sync` low for exactly 1600 cycles starting at line 490, `frame_start` spacing 420000.
- Coordinates: at the last active pixel -> `column`=639, `row`=479; through the following blanking, `column`=639 and `row`=479 are held; next `frame_start` -> 0/0.
- Mid-frame reset: assert `reset_n`=0 at h=300, v=200 -> outputs reach reset values without a clock edge; after release, the first edge gives `frame_start`=1, `column`=0, `row`=0.
- Frame counter: with `VGA_TIMING_FRAME_CNT_EN`, after the 4th `frame_start` -> `frame_cnt`=3; without the macro -> `frame_cnt`=0 throughout.
